// File: rtl/parity_serial_scheduler.sv
// Round-robin sequencer that feeds WIDTH-bit words from two requesters through a
// shared one-bit-per-clock XOR parity engine and returns an ID-tagged even-parity flag.
module parity_serial_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             res_valid,
  output logic             res_parity,
  output logic             res_id,
  input  logic             res_ready,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Even-parity flag: 1 when the accumulated XOR including the last bit is zero.
  function automatic logic final_even_parity(input logic acc, input logic last_bit);
    return ~(acc ^ last_bit);
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             acc_q, acc_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic             res_valid_q, res_valid_d;
  logic             res_parity_q, res_parity_d;
  logic             res_id_q, res_id_d;
  logic             busy_q, busy_d;

  logic             grant_valid_s;
  logic             grant_id_s;
  logic             accept_s;
  logic [WIDTH-1:0] grant_data_s;

  // Round-robin grant: a lone request wins, contention goes to the one not served last.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = ~last_grant_q;
    end else if (req0_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 1'b0;
    end else if (req1_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
      grant_id_s    = 1'b0;
    end
  end

  assign req0_ready   = (state_q == IDLE) && grant_valid_s && !grant_id_s && !rst;
  assign req1_ready   = (state_q == IDLE) && grant_valid_s &&  grant_id_s && !rst;
  assign accept_s     = req0_ready | req1_ready;
  assign grant_data_s = grant_id_s ? req1_data : req0_data;

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    acc_d        = acc_q;
    bit_cnt_d    = bit_cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    res_valid_d  = res_valid_q;
    res_parity_d = res_parity_q;
    res_id_d     = res_id_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          sr_d         = grant_data_s;
          acc_d        = 1'b0;
          bit_cnt_d    = '0;
          owner_d      = grant_id_s;
          last_grant_d = grant_id_s;
          state_d      = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        acc_d     = acc_q ^ sr_q[0];
        sr_d      = sr_q >> 1;
        bit_cnt_d = bit_cnt_q + CW'(1);
        // The last bit is folded straight into the result so it is valid on this edge.
        if (bit_cnt_q == LAST_CNT) begin
          res_parity_d = final_even_parity(acc_q, sr_q[0]);
          res_id_d     = owner_q;
          res_valid_d  = 1'b1;
          state_d      = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State registers; reset discards any in-flight job.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      acc_q        <= 1'b0;
      bit_cnt_q    <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      res_valid_q  <= 1'b0;
      res_parity_q <= 1'b0;
      res_id_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      acc_q        <= acc_d;
      bit_cnt_q    <= bit_cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      res_valid_q  <= res_valid_d;
      res_parity_q <= res_parity_d;
      res_id_q     <= res_id_d;
      busy_q       <= busy_d;
    end
  end

  assign res_valid  = res_valid_q;
  assign res_parity = res_parity_q;
  assign res_id     = res_id_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_parity_serial_scheduler.sv
// Self-checking bench: job-level model (owner, word parity, age since accept) compared
// against the scheduler every cycle, plus directed literal checks and random traffic.
module tb_parity_serial_scheduler;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid, res_ready;
  logic [WIDTH-1:0] req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic             res_valid, res_parity, res_id, busy;

  parity_serial_scheduler #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_parity (res_parity),
    .res_id     (res_id),
    .res_ready  (res_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: one outstanding job, its owner, its word parity, edges since accept.
  bit m_active = 1'b0;
  int m_age    = 0;
  bit m_id     = 1'b0;
  bit m_par    = 1'b0;
  bit m_last   = 1'b1;
  bit e_par    = 1'b0;
  bit e_id     = 1'b0;
  bit m_acc_evt = 1'b0;
  bit ret_ids[$];
  bit ret_pars[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit even_par(input logic [WIDTH-1:0] w);
    return ($countones(w) % 2) == 0;
  endfunction

  // One clock: drive inputs, check readies, advance model at the edge, check outputs.
  task automatic cycle(input logic r, input logic v0, input logic [WIDTH-1:0] d0,
                       input logic v1, input logic [WIDTH-1:0] d1, input logic rr);
    bit g_ok, g_id, e_r0, e_r1;
    rst = r; req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1; res_ready = rr;
    #1;
    g_ok = v0 || v1;
    g_id = (v0 && v1) ? !m_last : v1;
    e_r0 = !r && !m_active && g_ok && !g_id;
    e_r1 = !r && !m_active && g_ok && g_id;
    check("req0_ready", req0_ready, e_r0);
    check("req1_ready", req1_ready, e_r1);
    @(posedge clk);
    m_acc_evt = 1'b0;
    if (r) begin
      m_active = 1'b0; m_last = 1'b1; e_par = 1'b0; e_id = 1'b0;
    end else if (m_active) begin
      if (m_age >= WIDTH && rr) begin
        m_active = 1'b0;
        ret_ids.push_back(m_id);
        ret_pars.push_back(m_par);
      end else if (m_age < WIDTH) begin
        m_age++;
        if (m_age == WIDTH) begin
          e_par = m_par; e_id = m_id;
        end
      end
    end else if (e_r0 || e_r1) begin
      m_active = 1'b1; m_age = 0; m_id = g_id; m_last = g_id;
      m_par = even_par(g_id ? d1 : d0);
      m_acc_evt = 1'b1;
    end
    @(negedge clk);
    check("res_valid", res_valid, m_active && (m_age >= WIDTH));
    check("busy", busy, m_active);
    check("res_parity", res_parity, e_par);
    check("res_id", res_id, e_id);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    check("rst_res_valid_lit", res_valid, 1'b0);
    check("rst_busy_lit", busy, 1'b0);
    check("rst_res_parity_lit", res_parity, 1'b0);
    check("rst_res_id_lit", res_id, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (m_active && n < 40) begin
      cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      n++;
    end
    check("drain_done", m_active, 1'b0);
  endtask

  // Single-requester job with literal latency/parity/id expectations.
  task automatic run_single(input bit id, input logic [WIDTH-1:0] d, input bit exp_par);
    int n;
    n = 0;
    do begin
      cycle(1'b0, !id, d, id, d, 1'b0);
      n++;
    end while (!m_acc_evt && n < 20);
    check("accept_seen", m_acc_evt, 1'b1);
    n = 0;
    while (res_valid !== 1'b1 && n < 20) begin
      cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
      n++;
    end
    check("latency", n, WIDTH);
    check("res_parity_lit", res_parity, exp_par);
    check("res_id_lit", res_id, id);
    cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    check("busy_after_retire", busy, 1'b0);
  endtask

  initial begin
    int base, n;
    logic [WIDTH-1:0] w0, w1;

    do_reset();
    run_single(1'b0, 8'hA5, 1'b1);
    run_single(1'b1, 8'h07, 1'b0);
    run_single(1'b1, 8'h00, 1'b1);
    run_single(1'b1, 8'hFF, 1'b1);

    // Both valid from reset: req0 first, then req1.
    do_reset();
    base = ret_ids.size();
    n = 0;
    while (ret_ids.size() < base + 2 && n < 60) begin
      cycle(1'b0, 1'b1, 8'h01, 1'b1, 8'h03, 1'b1);
      n++;
    end
    drain();
    check("both_count", ret_ids.size(), base + 2);
    if (ret_ids.size() >= base + 2) begin
      check("both_first_id", ret_ids[base], 1'b0);
      check("both_first_par", ret_pars[base], 1'b0);
      check("both_second_id", ret_ids[base+1], 1'b1);
      check("both_second_par", ret_pars[base+1], 1'b1);
    end

    // Backpressure on an 8'h0F job while req1 keeps asking.
    do_reset();
    n = 0;
    do begin
      cycle(1'b0, 1'b1, 8'h0F, 1'b0, '0, 1'b0);
      n++;
    end while (!m_acc_evt && n < 20);
    n = 0;
    while (res_valid !== 1'b1 && n < 20) begin
      cycle(1'b0, 1'b0, '0, 1'b1, 8'h33, 1'b0);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 8'h55, 1'b1, 8'h33, 1'b0);
      check("bp_valid_lit", res_valid, 1'b1);
      check("bp_parity_lit", res_parity, 1'b1);
      check("bp_id_lit", res_id, 1'b0);
    end
    cycle(1'b0, 1'b1, 8'h55, 1'b1, 8'h33, 1'b1);
    check("bp_retired", res_valid, 1'b0);
    cycle(1'b0, 1'b1, 8'h55, 1'b1, 8'h33, 1'b1);
    check("bp_next_accept", m_acc_evt, 1'b1);
    drain();

    // Reset in the middle of shifting an 8'hA5 job.
    do_reset();
    n = 0;
    do begin
      cycle(1'b0, 1'b1, 8'hA5, 1'b0, '0, 1'b0);
      n++;
    end while (!m_acc_evt && n < 20);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b1, 8'hA5, 1'b1, 8'h33, 1'b1);
    check("midrst_valid_lit", res_valid, 1'b0);
    check("midrst_busy_lit", busy, 1'b0);
    run_single(1'b0, 8'h01, 1'b0);

    // Fairness: both continuously valid for six jobs, words refreshed on accept.
    do_reset();
    base = ret_ids.size();
    w0 = WIDTH'($urandom);
    w1 = WIDTH'($urandom);
    n = 0;
    while (ret_ids.size() < base + 6 && n < 200) begin
      cycle(1'b0, 1'b1, w0, 1'b1, w1, 1'b1);
      if (m_acc_evt) begin
        if (m_id) w1 = WIDTH'($urandom);
        else      w0 = WIDTH'($urandom);
      end
      n++;
    end
    drain();
    check("fair_count", ret_ids.size() >= base + 6, 1'b1);
    if (ret_ids.size() >= base + 6) begin
      for (int i = 0; i < 6; i++) check("fair_id_seq", ret_ids[base+i], i % 2);
    end

    // Random traffic with occasional resets and result backpressure.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 63) == 0, 1'($urandom), WIDTH'($urandom),
            1'($urandom), WIDTH'($urandom), 1'($urandom));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_serial_scheduler.md
Name: parity_serial_scheduler

Overview:
- Shares one serial running-parity engine (XOR accumulator, one bit per clock) between two requesters.
- Arbitrates round-robin and accepts a WIDTH-bit word over valid/ready.
- Shifts the word LSB-first through the engine, then returns an even-parity flag tagged with the requester ID over a valid/ready result port.
- Sits between word-level producers and the bit-serial parity datapath. It is the sequencer for that datapath.

Parameters:
- WIDTH, 8, word length in bits shifted per job (≥2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- req0_valid  input  1  requester 0 has a word.
- req0_data  input  WIDTH  requester 0 word.
- req0_ready  output  1  requester 0 word accepted this cycle if valid.
- req1_valid  input  1  requester 1 has a word.
- req1_data  input  WIDTH  requester 1 word.
- req1_ready  output  1  requester 1 word accepted this cycle if valid.
- res_valid  output  1  result available.
- res_parity  output  1  1 = even number of ones in word, 0 = odd.
- res_id  output  1  requester that owns the result.
- res_ready  input  1  consumer takes result.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (rst=1 at rising edge) forces the following, regardless of the current state or any in-flight job, which is discarded:
  - state=IDLE, shift reg=0, acc=0, bit_cnt=0, last_grant=1;
  - res_valid=0, res_parity=0, res_id=0, busy=0.
- While rst is high, req0_ready and req1_ready are 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, grant selection (combinational):
  - only reqN_valid → grant N;
  - both valid → grant the one ≠ last_grant;
  - none → no grant.
  - reqN_ready = (state==IDLE) & grant==N & !rst. At most one ready high at any time.
  - ready may depend combinationally on valid. Valid must not depend on ready.
- IDLE, on accept (valid&ready at an edge):
  - shift reg ← reqN_data, acc←0, bit_cnt←0, owner←N, last_grant←N;
  - state→SHIFT.
- SHIFT, each cycle:
  - acc ← acc ^ sr[0], sr ← sr>>1, bit_cnt ← bit_cnt+1.
  - bit_cnt has width $clog2(WIDTH)+1 and never wraps within a job.
  - On the cycle with bit_cnt==WIDTH-1, the final XOR is applied. At that edge: res_parity ← ~(acc ^ sr[0]), res_id ← owner, res_valid ← 1, state→DONE.
- DONE:
  - res_valid, res_parity and res_id stay stable until res_ready=1 at an edge. That edge sets res_valid←0 and state→IDLE.
  - No new word is accepted in the same edge as result retirement. The earliest next accept is the following cycle.
- Timing:
  - Latency: word accepted at edge k gives res_valid=1 after edge k+WIDTH.
  - Minimum job period is WIDTH+2 cycles with res_ready held high.
- Requester holds:
  - A requester whose valid is high but not granted holds data; it is not dropped.
  - Valid deasserting before grant is legal and simply withdraws the request.
- res_ready while res_valid=0 is ignored.
- Fairness: with both requesters continuously valid, grants strictly alternate.

Test Plan:
- Reset, then req0_valid=1, req0_data=8'hA5, res_ready=1:
  - req0_ready=1 in the first IDLE cycle;
  - res_valid rises 8 cycles after accept with res_parity=1, res_id=0;
  - busy low again one cycle after retire.
- req1 only, data=8'h07:
  - res_parity=0, res_id=1.
  - Repeat with 8'h00 → parity 1, and 8'hFF → parity 1.
- Both valid from reset, data0=8'h01, data1=8'h03, res_ready=1:
  - first grant req0 (last_grant resets to 1), result parity 0 id 0;
  - then req1, parity 1 id 1;
  - req1_ready never high while req0 job is active.
- Backpressure: 8'h0F job with res_ready=0 for 5 cycles after res_valid:
  - res_valid/res_parity=1/res_id held stable, no new ready asserted;
  - res_ready=1 retires it and the next accept follows one cycle later.
- Reset mid-SHIFT: assert rst at bit_cnt=3 of an 8'hA5 job:
  - next cycle state IDLE, res_valid=0, busy=0, readies low during rst;
  - after release a fresh 8'h01 job returns parity 0.
- Fairness: both valid continuously for 6 jobs:
  - res_id sequence 0,1,0,1,0,1;
  - each result matches popcount parity of the presented word.
